// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: hazard-controller FSM encoding, the default memory
// timeout, and the register-match helper used by the hazard detector.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int REG_W               = 5;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] dest,
                                     input logic [REG_W-1:0] src1,
                                     input logic [REG_W-1:0] src2,
                                     input logic             two_src);
    return (dest != '0) && ((dest == src1) || (two_src && (dest == src2)));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational RAW hazard detector for the instruction in ID against the
// producers sitting in EXE and MEM.
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  output logic             hazard
);

  logic exe_hit;
  logic mem_hit;

  assign exe_hit = reg_match(exe_dest, id_src1, id_src2, id_two_src);
  assign mem_hit = reg_match(mem_dest, id_src1, id_src2, id_two_src);

  // With forwarding only a load in EXE cannot be bypassed in time.
  always_comb begin
    hazard = 1'b0;
    if (id_valid) begin
      if (fwd_en) hazard = exe_wb_en & exe_mem_read & exe_hit;
      else        hazard = (exe_wb_en & exe_hit) | (mem_wb_en & mem_hit);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: bubble insertion, branch flush, and a memory-wait
// FSM with timeout detection plus stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic [REG_W-1:0] exe_dest,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             id_exe_freeze,
  output logic             exe_mem_freeze,
  output logic             if_id_flush,
  output logic             id_exe_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout_err,
  output state_t           state_dbg
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              hazard;
  logic              mem_stall;

  hazard_detect u_hazard_detect (
    .fwd_en       (fwd_en),
    .id_valid     (id_valid),
    .id_two_src   (id_two_src),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_dest     (exe_dest),
    .mem_wb_en    (mem_wb_en),
    .mem_dest     (mem_dest),
    .hazard       (hazard)
  );

  assign mem_stall = mem_req & ~mem_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:      if (mem_stall) next_state = MEM_WAIT;
      MEM_WAIT: if (mem_ready) next_state = RUN;
      default:  next_state = RUN;
    endcase
  end

  // Memory stall outranks branch flush, which outranks bubble insertion.
  always_comb begin
    pc_freeze      = 1'b0;
    if_id_freeze   = 1'b0;
    id_exe_freeze  = 1'b0;
    exe_mem_freeze = 1'b0;
    if_id_flush    = 1'b0;
    id_exe_flush   = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (mem_stall) begin
            pc_freeze      = 1'b1;
            if_id_freeze   = 1'b1;
            id_exe_freeze  = 1'b1;
            exe_mem_freeze = 1'b1;
          end else if (br_taken) begin
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
          end else if (hazard) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_exe_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          pc_freeze      = ~mem_ready;
          if_id_freeze   = ~mem_ready;
          id_exe_freeze  = ~mem_ready;
          exe_mem_freeze = ~mem_ready;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt        <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (pc_freeze && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (if_id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      if (state == RUN) begin
        if (mem_stall) wait_cnt <= '0;
      end else if (!mem_ready) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
        // The cycle that brings the count to the limit raises the flag.
        if (wait_cnt >= WAIT_MAX - WAIT_W'(1)) mem_timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl, checked cycle-by-cycle
// against a behavioural reference model through an expected-value queue.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W   = 4;
  localparam int TMO     = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int W       = 16;

  typedef struct {
    logic       rst;
    logic       fwd_en;
    logic       id_valid;
    logic       id_two_src;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic       exe_wb_en;
    logic       exe_mem_read;
    logic [4:0] exe_dest;
    logic       mem_wb_en;
    logic [4:0] mem_dest;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ready;
  } stim_t;

  logic clk = 1'b0;
  logic rst, fwd_en, id_valid, id_two_src, exe_wb_en, exe_mem_read, mem_wb_en;
  logic br_taken, mem_req, mem_ready;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, if_id_flush, id_exe_flush;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_timeout_err;
  state_t state_dbg;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model state: waiting flag, wait-cycle count, counters, sticky error.
  bit m_wait;
  int m_wcnt;
  int m_stall;
  int m_flush;
  bit m_err;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid), .id_two_src(id_two_src),
    .id_src1(id_src1), .id_src2(id_src2), .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read),
    .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_freeze(pc_freeze), .if_id_freeze(if_id_freeze),
    .id_exe_freeze(id_exe_freeze), .exe_mem_freeze(exe_mem_freeze), .if_id_flush(if_id_flush),
    .id_exe_flush(id_exe_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout_err(mem_timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [5:0] dut_ctrl();
    return {pc_freeze, if_id_freeze, id_exe_freeze, exe_mem_freeze, if_id_flush, id_exe_flush};
  endfunction

  // Monitor: outputs are presented every cycle; compare at the falling edge.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("ctrl", W'(dut_ctrl()), W'(e[15:10]));
        check("stall_cnt", W'(stall_cnt), W'(e[9:6]));
        check("flush_cnt", W'(flush_cnt), W'(e[5:2]));
        check("mem_timeout_err", W'(mem_timeout_err), W'(e[1]));
        check("state", W'(state_dbg == MEM_WAIT), W'(e[0]));
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic bit model_hazard(input stim_t s);
    int  srcs[$];
    bit  hit_exe;
    bit  hit_mem;
    hit_exe = 0;
    hit_mem = 0;
    srcs.push_back(int'(s.id_src1));
    if (s.id_two_src) srcs.push_back(int'(s.id_src2));
    foreach (srcs[i]) begin
      if (s.exe_dest != 0 && srcs[i] == int'(s.exe_dest)) hit_exe = 1;
      if (s.mem_dest != 0 && srcs[i] == int'(s.mem_dest)) hit_mem = 1;
    end
    if (!s.id_valid) return 0;
    if (s.fwd_en) return s.exe_wb_en && s.exe_mem_read && hit_exe;
    return (s.exe_wb_en && hit_exe) || (s.mem_wb_en && hit_mem);
  endfunction

  task automatic model_step(input stim_t s);
    logic [5:0] ctrl;
    bit stalled;
    stalled = s.mem_req && !s.mem_ready;
    ctrl = 6'b000000;
    if (s.rst) begin
      if (m_wait)                 ctrl = s.mem_ready ? 6'b000000 : 6'b111100;
      else if (stalled)           ctrl = 6'b111100;
      else if (s.br_taken)        ctrl = 6'b000011;
      else if (model_hazard(s))   ctrl = 6'b110001;
    end
    exp_q.push_back({ctrl, 4'(m_stall), 4'(m_flush), m_err, m_wait});
    if (!s.rst) begin
      m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_err = 0;
    end else begin
      if (ctrl[5]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
      if (ctrl[1]) m_flush = (m_flush < CNT_MAX) ? m_flush + 1 : CNT_MAX;
      if (m_wait) begin
        if (s.mem_ready) m_wait = 0;
        else begin
          m_wcnt++;
          if (m_wcnt >= TMO) m_err = 1;
        end
      end else if (stalled) begin
        m_wait = 1;
        m_wcnt = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b1, fwd_en: 1'b1, id_valid: 1'b0, id_two_src: 1'b0, id_src1: 5'd0,
          id_src2: 5'd0, exe_wb_en: 1'b0, exe_mem_read: 1'b0, exe_dest: 5'd0,
          mem_wb_en: 1'b0, mem_dest: 5'd0, br_taken: 1'b0, mem_req: 1'b0, mem_ready: 1'b1};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; fwd_en = s.fwd_en; id_valid = s.id_valid; id_two_src = s.id_two_src;
    id_src1 = s.id_src1; id_src2 = s.id_src2; exe_wb_en = s.exe_wb_en;
    exe_mem_read = s.exe_mem_read; exe_dest = s.exe_dest; mem_wb_en = s.mem_wb_en;
    mem_dest = s.mem_dest; br_taken = s.br_taken; mem_req = s.mem_req; mem_ready = s.mem_ready;
  endtask

  task automatic send(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    model_step(s);
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle();
    s.rst = 1'b0;
    send(s);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    stim_t s;
    stim_t r;
    drive(idle());
    rst = 1'b0;
    repeat (2) @(posedge clk);
    m_wait = 0; m_wcnt = 0; m_stall = 0; m_flush = 0; m_err = 0;

    // Reset state: outputs low and counters clear while rst is held.
    do_reset();
    settle();
    check("reset_ctrl", W'(dut_ctrl()), '0);

    // Load-use hazard with forwarding: one-cycle bubble.
    s = idle();
    s.id_valid = 1; s.exe_wb_en = 1; s.exe_mem_read = 1; s.exe_dest = 5'd5; s.id_src1 = 5'd5;
    send(s);
    settle();
    check("load_use_bubble", W'(dut_ctrl()), W'(6'b110001));
    send(idle());
    settle();
    check("load_use_stall_cnt", W'(stall_cnt), W'(1));

    // No forwarding: MEM producer on src2 hazards; destination 0 never does.
    do_reset();
    s = idle();
    s.fwd_en = 0; s.id_valid = 1; s.id_two_src = 1; s.id_src1 = 5'd3; s.id_src2 = 5'd7;
    s.mem_wb_en = 1; s.mem_dest = 5'd7;
    send(s);
    settle();
    check("nofwd_mem_hazard", W'(pc_freeze), W'(1));
    s.mem_dest = 5'd0; s.id_src2 = 5'd0;
    send(s);
    settle();
    check("nofwd_r0_no_hazard", W'(dut_ctrl()), '0);

    // Taken branch beats a simultaneous hazard.
    do_reset();
    s = idle();
    s.id_valid = 1; s.exe_wb_en = 1; s.exe_mem_read = 1; s.exe_dest = 5'd9; s.id_src1 = 5'd9;
    s.br_taken = 1;
    send(s);
    settle();
    check("branch_over_hazard", W'(dut_ctrl()), W'(6'b000011));
    send(idle());
    settle();
    check("branch_flush_cnt", W'(flush_cnt), W'(1));

    // Memory wait for four cycles, released on the fifth.
    do_reset();
    s = idle();
    s.mem_req = 1; s.mem_ready = 0; s.br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      send(s);
      settle();
      check("mem_wait_freeze", W'(dut_ctrl()), W'(6'b111100));
    end
    s.mem_ready = 1;
    send(s);
    settle();
    check("mem_release", W'(dut_ctrl()), '0);
    send(idle());
    settle();
    check("mem_wait_stall_cnt", W'(stall_cnt), W'(4));

    // Timeout after TMO waiting cycles, then reset mid-wait.
    do_reset();
    s = idle();
    s.mem_req = 1; s.mem_ready = 0;
    send(s);
    for (int i = 0; i < TMO; i++) send(s);
    settle();
    check("timeout_not_yet", W'(mem_timeout_err), '0);
    send(s);
    settle();
    check("timeout_set", W'(mem_timeout_err), W'(1));
    do_reset();
    send(idle());
    settle();
    check("post_reset_state", W'(state_dbg == MEM_WAIT), '0);
    check("post_reset_err", W'(mem_timeout_err), '0);
    check("post_reset_stall", W'(stall_cnt), '0);

    // Randomized traffic with occasional resets; counters saturate at CNT_W bits.
    for (int n = 0; n < 1500; n++) begin
      r.rst          = ($urandom_range(0, 59) != 0);
      r.fwd_en       = 1'($urandom_range(0, 1));
      r.id_valid     = ($urandom_range(0, 3) != 0);
      r.id_two_src   = 1'($urandom_range(0, 1));
      r.id_src1      = 5'($urandom_range(0, 3));
      r.id_src2      = 5'($urandom_range(0, 3));
      r.exe_wb_en    = 1'($urandom_range(0, 1));
      r.exe_mem_read = 1'($urandom_range(0, 1));
      r.exe_dest     = 5'($urandom_range(0, 3));
      r.mem_wb_en    = 1'($urandom_range(0, 1));
      r.mem_dest     = 5'($urandom_range(0, 3));
      r.br_taken     = ($urandom_range(0, 4) == 0);
      r.mem_req      = ($urandom_range(0, 3) == 0);
      r.mem_ready    = (n % 200 < 40) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
      send(r);
    end

    send(idle());
    repeat (2) @(posedge clk);
    settle();
    check("queue_drained", W'(exp_q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
